// File: rtl/cla_sum_checker.sv
// Result checker for cla_adder16: captures a vector, waits a settle window, then compares the adder outputs.
// Optional CLA_CHECK_STABLE_EN: also requires the adder outputs to be unchanged between the last settle cycle and the check cycle.
//
// state  | meaning
// IDLE   | waiting for start; a start here captures the vector
// SETTLE | counting down while the adder ripples
// CHECK  | sample dut outputs, compare, update statistics, pulse done
module cla_sum_checker #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 15,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] expected_sum,
  output logic             expected_cout,
  output logic [CNT_W-1:0] vector_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             overrun
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t            state;
  logic [SCNT_W-1:0] settle_cnt;
  logic [WIDTH:0]    sum_full;
  logic              match;

`ifdef CLA_CHECK_STABLE_EN
  logic [WIDTH-1:0]  stab_sum;
  logic              stab_cout;
`endif

  assign sum_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

  // Case equality so an undriven or X adder output counts as a mismatch.
  always_comb begin
    match = (dut_sum === expected_sum) && (dut_cout === expected_cout);
`ifdef CLA_CHECK_STABLE_EN
    match = match && (stab_sum === dut_sum) && (stab_cout === dut_cout);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      expected_sum  <= '0;
      expected_cout <= 1'b0;
      vector_cnt    <= '0;
      mismatch_cnt  <= '0;
      overrun       <= 1'b0;
`ifdef CLA_CHECK_STABLE_EN
      stab_sum      <= '0;
      stab_cout     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expected_sum  <= sum_full[WIDTH-1:0];
            expected_cout <= sum_full[WIDTH];
            settle_cnt    <= SETTLE_LOAD;
            busy          <= 1'b1;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (start) overrun <= 1'b1;
          if (settle_cnt == '0) begin
            state <= CHECK;
`ifdef CLA_CHECK_STABLE_EN
            stab_sum  <= dut_sum;
            stab_cout <= dut_cout;
`endif
          end else begin
            settle_cnt <= settle_cnt - SCNT_W'(1);
          end
        end
        CHECK: begin
          if (start) overrun <= 1'b1;
          pass <= match;
          done <= 1'b1;
          busy <= 1'b0;
          if (vector_cnt != '1) vector_cnt <= vector_cnt + CNT_W'(1);
          if (!match && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_sum_checker.sv
// Directed bench for cla_sum_checker: the bench plays the adder and drives dut_sum/dut_cout directly.
module tb_cla_sum_checker;

  localparam int WIDTH = 16;
  localparam int SETTLE_CYCLES = 15;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b, dut_sum;
  logic             carry_in, dut_cout;
  logic             busy, done, pass, expected_cout, overrun;
  logic [WIDTH-1:0] expected_sum;
  logic [CNT_W-1:0] vector_cnt, mismatch_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  cla_sum_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
    .expected_sum(expected_sum), .expected_cout(expected_cout),
    .vector_cnt(vector_cnt), .mismatch_cnt(mismatch_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // Called at a negedge: presents a vector with start, returns edges from capture to done (-1 on timeout).
  task automatic run_vec(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [15:0] ds, input logic dc, output int lat, output logic busy1);
    a = va; b = vb; carry_in = vc; dut_sum = ds; dut_cout = dc; start = 1'b1;
    lat = -1; busy1 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b0; busy1 = busy; end
      if (done) begin lat = i - 1; break; end
    end
  endtask

  int   lat;
  logic bz;
  int   done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_exp_sum", 32'(expected_sum), 0);
    check("rst_exp_cout", 32'(expected_cout), 0);
    check("rst_vector_cnt", 32'(vector_cnt), 0);
    check("rst_mismatch_cnt", 32'(mismatch_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 10+22
    run_vec(16'd10, 16'd22, 1'b0, 16'd32, 1'b0, lat, bz);
    check("v1_busy", 32'(bz), 1);
    check("v1_latency", 32'(lat), SETTLE_CYCLES + 1);
    check("v1_pass", 32'(pass), 1);
    check("v1_exp_sum", 32'(expected_sum), 32);
    check("v1_exp_cout", 32'(expected_cout), 0);
    check("v1_vector_cnt", 32'(vector_cnt), 1);

    // back-to-back from here on: each start lands in the done cycle
    run_vec(16'd32768, 16'd65535, 1'b0, 16'd32767, 1'b1, lat, bz);
    check("v2_latency", 32'(lat), SETTLE_CYCLES + 1);
    check("v2_pass", 32'(pass), 1);
    check("v2_exp_sum", 32'(expected_sum), 32767);
    check("v2_exp_cout", 32'(expected_cout), 1);

    run_vec(16'd32767, 16'd32767, 1'b1, 16'd65535, 1'b0, lat, bz);
    check("v3a_pass", 32'(pass), 1);
    check("v3a_exp_sum", 32'(expected_sum), 65535);
    check("v3a_exp_cout", 32'(expected_cout), 0);

    run_vec(16'd65535, 16'd65535, 1'b0, 16'd65534, 1'b1, lat, bz);
    check("v3b_pass", 32'(pass), 1);
    check("v3b_exp_sum", 32'(expected_sum), 65534);
    check("v3b_exp_cout", 32'(expected_cout), 1);

    run_vec(16'd0, 16'd0, 1'b0, 16'd1, 1'b0, lat, bz);
    check("v4_pass", 32'(pass), 0);
    check("v4_exp_sum", 32'(expected_sum), 0);
    check("v4_mismatch_cnt", 32'(mismatch_cnt), 1);
    check("v4_vector_cnt", 32'(vector_cnt), 5);

    run_vec(16'd7, 16'd8, 1'b0, 16'bx, 1'b0, lat, bz);
    check("vx_pass", 32'(pass), 0);
    check("vx_mismatch_cnt", 32'(mismatch_cnt), 2);
    check("vx_done_pulse_len", 32'(lat), SETTLE_CYCLES + 1);

    // second start 5 clocks into SETTLE must be dropped
    a = 16'd5; b = 16'd6; carry_in = 1'b0; dut_sum = 16'd11; dut_cout = 1'b0; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; a = 16'd100; b = 16'd1; end
      if (i == 6) start = 1'b0;
      if (done) begin lat = i - 1; break; end
    end
    check("ovr_latency", 32'(lat), SETTLE_CYCLES + 1);
    check("ovr_exp_sum", 32'(expected_sum), 11);
    check("ovr_pass", 32'(pass), 1);
    check("ovr_flag", 32'(overrun), 1);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("ovr_no_extra_done", 32'(done_seen), 0);
    check("ovr_vector_cnt", 32'(vector_cnt), 7);
    check("ovr_busy_idle", 32'(busy), 0);

    // reset in the middle of SETTLE
    a = 16'd3; b = 16'd4; dut_sum = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_pass", 32'(pass), 0);
    check("mrst_exp_sum", 32'(expected_sum), 0);
    check("mrst_vector_cnt", 32'(vector_cnt), 0);
    check("mrst_mismatch_cnt", 32'(mismatch_cnt), 0);
    check("mrst_overrun", 32'(overrun), 0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("mrst_no_done", 32'(done_seen), 0);

    // outputs change between last SETTLE cycle and CHECK: only the stable-check build flags it
    a = 16'd1; b = 16'd1; carry_in = 1'b0; dut_sum = 16'd0; dut_cout = 1'b0; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == SETTLE_CYCLES + 1) dut_sum = 16'd2;
      if (done) begin lat = i - 1; break; end
    end
    check("flip_latency", 32'(lat), SETTLE_CYCLES + 1);
    check("flip_exp_sum", 32'(expected_sum), 2);
`ifdef CLA_CHECK_STABLE_EN
    check("flip_pass", 32'(pass), 0);
    check("flip_mismatch_cnt", 32'(mismatch_cnt), 1);
`else
    check("flip_pass", 32'(pass), 1);
    check("flip_mismatch_cnt", 32'(mismatch_cnt), 0);
`endif
    check("flip_vector_cnt", 32'(vector_cnt), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
